alu_fitness_collector: RTL and testbench

Hardware-side fitness evaluator for the ALU genetic-algorithm test flow. It consumes the ALU transactions that one chromosome's stimulus produced, as seen by the output monitor. It accumulates functional-coverage bins hit by that chromosome and returns a fitness score plus a completion handshake to the GA controller. It is the consuming end of the chromosome-driven generator: the generator writes `TRANS_COUNT` transactions per chromosome; this block reads them back and scores them.

---
 rtl/alu_fitness_collector.sv | 110 +++++++++++
 tb/tb_alu_fitness_collector.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_fitness_collector.sv
// Functional-coverage fitness scorer for one GA chromosome: bins monitored ALU
// transactions into a 256-bit hit map and reports the distinct-bin count.
module alu_fitness_collector #(
    parameter int DATA_WIDTH     = 8,
    parameter int TRANS_COUNT    = 100,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mon_vld,
    input  logic [3:0]            mon_op,
    input  logic [1:0]            mon_movi,
    input  logic [DATA_WIDTH-1:0] mon_a,
    input  logic                  fitness_rdy,
    output logic [8:0]            fitness,
    output logic                  fitness_vld,
    output logic                  timeout,
    output logic [15:0]           trans_seen,
    output logic                  busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_REPORT
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [255:0]  bitmap;
    logic [15:0]   idle_cnt;
    logic [7:0]    bin;
    logic          hit_new;
    logic          last_trans;
    logic          idle_expire;
    logic          unused_a_bits;

    // Operand A contributes only its range (top two bits) to the bin.
    assign bin           = {mon_op, mon_movi, mon_a[DATA_WIDTH-1 -: 2]};
    assign unused_a_bits = ^mon_a[DATA_WIDTH-3:0];

    assign hit_new     = ~bitmap[bin];
    assign last_trans  = (trans_seen + 16'd1) == 16'(TRANS_COUNT);
    assign idle_expire = (idle_cnt + 16'd1) == 16'(TIMEOUT_CYCLES);

    assign fitness_vld = (state == S_REPORT);
    assign busy        = (state != S_IDLE);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        // NOTE: default assigned first so no path leaves state_next unassigned (no latch).
        state_next = state;
        case (state)
            S_IDLE:    if (start) state_next = S_COLLECT;
            S_COLLECT: begin
                if (mon_vld) begin
                    if (last_trans) state_next = S_REPORT;
                end else if (idle_expire) begin
                    state_next = S_REPORT;
                end
            end
            S_REPORT:  if (fitness_rdy) state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the hit map is reset too, since its cleared state is architecturally visible.
            bitmap     <= '0;
            fitness    <= '0;
            trans_seen <= '0;
            idle_cnt   <= '0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bitmap     <= '0;
                        fitness    <= '0;
                        trans_seen <= '0;
                        idle_cnt   <= '0;
                        timeout    <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    if (mon_vld) begin
                        trans_seen <= trans_seen + 16'd1;
                        idle_cnt   <= '0;
                        if (hit_new) begin
                            bitmap[bin] <= 1'b1;
                            fitness     <= fitness + 9'd1;
                        end
                    end else begin
                        idle_cnt <= idle_cnt + 16'd1;
                        if (idle_expire) timeout <= 1'b1;
                    end
                end
                default: ;  // REPORT and unused encodings hold the result
            endcase
        end
    end

endmodule

// File: tb/tb_alu_fitness_collector.sv
// Bench for alu_fitness_collector: three parameterisations share one stimulus
// stream and are each compared every cycle against a spec-level model.
module tb_alu_fitness_collector;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mon_vld;
    logic [3:0] mon_op;
    logic [1:0] mon_movi;
    logic [7:0] mon_a;
    logic       fitness_rdy;

    logic [8:0]  fit_o  [3];
    logic        fvld_o [3];
    logic        to_o   [3];
    logic [15:0] seen_o [3];
    logic        busy_o [3];

    int tc_of [3] = '{4, 100, 256};
    int to_of [3] = '{5, 8, 12};

    int checks = 0;
    int errors = 0;

    // Spec-level model: phase 0 = idle, 1 = collect, 2 = report.
    int m_phase [3];
    int m_fit   [3];
    int m_seen  [3];
    int m_idle  [3];
    int m_to    [3];
    bit m_bins  [3][256];

    always #5 clk = ~clk;

    alu_fitness_collector #(.DATA_WIDTH(8), .TRANS_COUNT(4), .TIMEOUT_CYCLES(5)) u0 (
        .clk(clk), .rst(rst), .start(start), .mon_vld(mon_vld), .mon_op(mon_op),
        .mon_movi(mon_movi), .mon_a(mon_a), .fitness_rdy(fitness_rdy),
        .fitness(fit_o[0]), .fitness_vld(fvld_o[0]), .timeout(to_o[0]),
        .trans_seen(seen_o[0]), .busy(busy_o[0]));

    alu_fitness_collector #(.DATA_WIDTH(8), .TRANS_COUNT(100), .TIMEOUT_CYCLES(8)) u1 (
        .clk(clk), .rst(rst), .start(start), .mon_vld(mon_vld), .mon_op(mon_op),
        .mon_movi(mon_movi), .mon_a(mon_a), .fitness_rdy(fitness_rdy),
        .fitness(fit_o[1]), .fitness_vld(fvld_o[1]), .timeout(to_o[1]),
        .trans_seen(seen_o[1]), .busy(busy_o[1]));

    alu_fitness_collector #(.DATA_WIDTH(8), .TRANS_COUNT(256), .TIMEOUT_CYCLES(12)) u2 (
        .clk(clk), .rst(rst), .start(start), .mon_vld(mon_vld), .mon_op(mon_op),
        .mon_movi(mon_movi), .mon_a(mon_a), .fitness_rdy(fitness_rdy),
        .fitness(fit_o[2]), .fitness_vld(fvld_o[2]), .timeout(to_o[2]),
        .trans_seen(seen_o[2]), .busy(busy_o[2]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_clear(input int i);
        m_fit[i]  = 0;
        m_seen[i] = 0;
        m_idle[i] = 0;
        m_to[i]   = 0;
        for (int b = 0; b < 256; b++) m_bins[i][b] = 1'b0;
    endtask

    // Advance the model over one clock edge using the inputs currently applied.
    task automatic model_step();
        int b;
        b = int'(mon_op) * 16 + int'(mon_movi) * 4 + int'(mon_a) / 64;
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                model_clear(i);
                m_phase[i] = 0;
            end else if (m_phase[i] == 0) begin
                if (start) begin
                    model_clear(i);
                    m_phase[i] = 1;
                end
            end else if (m_phase[i] == 1) begin
                if (mon_vld) begin
                    m_seen[i]++;
                    m_idle[i] = 0;
                    if (!m_bins[i][b]) begin
                        m_bins[i][b] = 1'b1;
                        m_fit[i]++;
                    end
                    if (m_seen[i] == tc_of[i]) m_phase[i] = 2;
                end else begin
                    m_idle[i]++;
                    if (m_idle[i] == to_of[i]) begin
                        m_to[i]    = 1;
                        m_phase[i] = 2;
                    end
                end
            end else begin
                if (fitness_rdy) m_phase[i] = 0;
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d.fitness", i),     32'(fit_o[i]),  32'(m_fit[i]));
            check($sformatf("u%0d.trans_seen", i),  32'(seen_o[i]), 32'(m_seen[i]));
            check($sformatf("u%0d.timeout", i),     32'(to_o[i]),   32'(m_to[i]));
            check($sformatf("u%0d.fitness_vld", i), 32'(fvld_o[i]), 32'(m_phase[i] == 2));
            check($sformatf("u%0d.busy", i),        32'(busy_o[i]), 32'(m_phase[i] != 0));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic quiet();
        start = 0; mon_vld = 0; fitness_rdy = 0; rst = 0;
    endtask

    task automatic send(input int op, input int movi, input int a);
        mon_vld = 1; mon_op = 4'(op); mon_movi = 2'(movi); mon_a = 8'(a);
    endtask

    // Let every instance time out and hand back its result, ending in IDLE.
    task automatic settle();
        quiet();
        fitness_rdy = 1;
        repeat (20) cycle();
        fitness_rdy = 0;
        for (int i = 0; i < 3; i++) check($sformatf("settle.u%0d.busy", i), 32'(busy_o[i]), 0);
    endtask

    typedef struct {
        bit start;
        bit vld;
        int op;
        bit rdy;
        int fit;
        int seen;
        bit fvld;
        bit busy;
    } vec_t;

    vec_t tbl [8];

    initial begin
        for (int i = 0; i < 3; i++) begin
            model_clear(i);
            m_phase[i] = 0;
        end
        mon_op = 0; mon_movi = 0; mon_a = 0;

        // Back-to-back scoring on TRANS_COUNT = 4, then RDY+START together in REPORT.
        tbl[0] = '{1, 0, 0, 0, 0, 0, 0, 1};
        tbl[1] = '{0, 1, 0, 0, 1, 1, 0, 1};
        tbl[2] = '{0, 1, 1, 0, 2, 2, 0, 1};
        tbl[3] = '{0, 1, 2, 0, 3, 3, 0, 1};
        tbl[4] = '{0, 1, 3, 0, 4, 4, 1, 1};
        tbl[5] = '{0, 1, 7, 0, 4, 4, 1, 1};
        tbl[6] = '{1, 0, 0, 1, 4, 4, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 4, 4, 0, 0};

        // Reset, then idle with stray MON_VLD pulses.
        quiet();
        rst = 1;
        repeat (2) cycle();
        rst = 0;
        for (int c = 0; c < 10; c++) begin
            mon_vld = c[0];
            cycle();
        end
        mon_vld = 0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle.u%0d.trans_seen", i), 32'(seen_o[i]), 0);
            check($sformatf("idle.u%0d.fitness", i),    32'(fit_o[i]),  0);
            check($sformatf("idle.u%0d.busy", i),       32'(busy_o[i]), 0);
        end

        for (int v = 0; v < 8; v++) begin
            start = tbl[v].start;
            mon_vld = tbl[v].vld;
            mon_op = 4'(tbl[v].op); mon_movi = 0; mon_a = 0;
            fitness_rdy = tbl[v].rdy;
            cycle();
            check($sformatf("tbl%0d.fitness", v),     32'(fit_o[0]),  32'(tbl[v].fit));
            check($sformatf("tbl%0d.trans_seen", v),  32'(seen_o[0]), 32'(tbl[v].seen));
            check($sformatf("tbl%0d.fitness_vld", v), 32'(fvld_o[0]), 32'(tbl[v].fvld));
            check($sformatf("tbl%0d.busy", v),        32'(busy_o[0]), 32'(tbl[v].busy));
            check($sformatf("tbl%0d.timeout", v),     32'(to_o[0]),   0);
        end
        settle();

        // 100 identical transactions, then a 20-cycle stall with extra MON_VLD.
        start = 1; cycle(); start = 0;
        for (int n = 0; n < 100; n++) begin
            send(5, 2, 8'hC0);
            cycle();
        end
        check("same100.fitness", 32'(fit_o[1]), 1);
        check("same100.trans_seen", 32'(seen_o[1]), 100);
        check("same100.fitness_vld", 32'(fvld_o[1]), 1);
        for (int n = 0; n < 20; n++) begin
            quiet();
            if (n % 3 == 0) send(n % 16, 1, n * 13);
            cycle();
            check("stall.fitness_vld", 32'(fvld_o[1]), 1);
            check("stall.trans_seen", 32'(seen_o[1]), 100);
            check("stall.fitness", 32'(fit_o[1]), 1);
        end
        settle();

        // Idle timeout after exactly 8 quiet cycles.
        start = 1; cycle(); start = 0;
        for (int n = 1; n <= 3; n++) begin
            send(n, 0, 0);
            cycle();
        end
        mon_vld = 0;
        for (int n = 1; n <= 7; n++) begin
            cycle();
            check("to.early_vld", 32'(fvld_o[1]), 0);
        end
        cycle();
        check("to.fitness_vld", 32'(fvld_o[1]), 1);
        check("to.timeout", 32'(to_o[1]), 1);
        check("to.fitness", 32'(fit_o[1]), 3);
        check("to.trans_seen", 32'(seen_o[1]), 3);
        settle();

        // Transaction on the 8th idle edge beats the timeout.
        start = 1; cycle(); start = 0;
        for (int n = 1; n <= 3; n++) begin
            send(n, 0, 0);
            cycle();
        end
        mon_vld = 0;
        repeat (7) cycle();
        send(4, 0, 0);
        cycle();
        mon_vld = 0;
        check("race.fitness_vld", 32'(fvld_o[1]), 0);
        check("race.timeout", 32'(to_o[1]), 0);
        check("race.trans_seen", 32'(seen_o[1]), 4);
        cycle();
        check("race.after_vld", 32'(fvld_o[1]), 0);
        settle();

        // Full 256-bin sweep, accept, restart, one transaction.
        start = 1; cycle(); start = 0;
        for (int b = 0; b < 256; b++) begin
            send(b / 16, (b / 4) % 4, (b % 4) * 64 + int'($urandom_range(0, 63)));
            cycle();
        end
        quiet();
        check("sweep.fitness", 32'(fit_o[2]), 256);
        check("sweep.trans_seen", 32'(seen_o[2]), 256);
        check("sweep.fitness_vld", 32'(fvld_o[2]), 1);
        fitness_rdy = 1; cycle(); fitness_rdy = 0;
        check("sweep.accepted", 32'(fvld_o[2]), 0);
        start = 1; cycle(); start = 0;
        send(9, 3, 8'h40);
        cycle();
        quiet();
        check("restart.fitness", 32'(fit_o[2]), 1);
        check("restart.trans_seen", 32'(seen_o[2]), 1);
        settle();

        // START inside COLLECT is ignored; reset mid-COLLECT clears everything.
        start = 1; cycle(); start = 0;
        for (int n = 0; n < 50; n++) begin
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
            start = (n == 20);
            cycle();
            if (n == 20) begin
                check("start_in_collect.trans_seen", 32'(seen_o[1]), 21);
                check("start_in_collect.busy", 32'(busy_o[1]), 1);
            end
        end
        quiet();
        rst = 1;
        send(1, 1, 1);
        cycle();
        quiet();
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst.u%0d.fitness", i),     32'(fit_o[i]),  0);
            check($sformatf("rst.u%0d.trans_seen", i),  32'(seen_o[i]), 0);
            check($sformatf("rst.u%0d.fitness_vld", i), 32'(fvld_o[i]), 0);
            check($sformatf("rst.u%0d.busy", i),        32'(busy_o[i]), 0);
        end

        // Randomized traffic with varying density, checked every cycle.
        for (int seg = 0; seg < 40; seg++) begin
            int vld_pct;
            int op_max;
            vld_pct = int'($urandom_range(10, 100));
            op_max  = int'($urandom_range(0, 15));
            for (int c = 0; c < 60; c++) begin
                rst         = ($urandom_range(0, 299) == 0);
                start       = ($urandom_range(0, 7) == 0);
                fitness_rdy = ($urandom_range(0, 2) == 0);
                mon_vld     = ($urandom_range(1, 100) <= vld_pct);
                mon_op      = 4'($urandom_range(0, op_max));
                mon_movi    = 2'($urandom_range(0, 3));
                mon_a       = 8'($urandom_range(0, 255));
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
